uart_rx_frame: RTL and testbench
================================

UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flops in the rs232_rx synchronizer (legal range 2..4).
REQ-002 clk  input  1  system clock (50 MHz); all logic on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 rs232_rx  input  1  asynchronous serial line; idle high.
REQ-005 clk_bps  input  1  one-cycle pulse from the baud-rate divider marking mid-bit sample points.
REQ-006 bps_start  output  1  held high while a frame is being received; enables the baud-rate divider.
REQ-007 rx_data  output  8  last correctly received byte.
REQ-008 rx_valid  output  1  one-cycle pulse; rx_data updated this cycle.
REQ-009 rx_frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-010 rx_parity_err  output  1  one-cycle pulse; parity mismatch (constant 0 when RX_PARITY_EN is undefined).

Function
REQ-011 rs232_rx passes through SYNC_STAGES flops, then one history flop; a start edge is detected when history=1 and synchronized=0.
REQ-012 States: IDLE, START, DATA, PARITY (only with RX_PARITY_EN), STOP.
REQ-013 IDLE: on a detected start edge, go to START and set bps_start to 1 on the same clock edge.
REQ-014 START: on clk_bps, if the synchronized line = 1 (false start), return to IDLE and clear bps_start; otherwise go to DATA with bit counter = 0.
REQ-015 DATA: on each clk_bps, shift the synchronized line into the shift register LSB-first and increment the 3-bit counter.
REQ-016 DATA exit: after the 8th sample (counter wraps 7->0), go to PARITY if enabled, else STOP.
REQ-017 STOP: on clk_bps, sample the line, then return to IDLE and clear bps_start on the same clock edge.
REQ-018 STOP sample = 1 with no parity error: rx_data <= shift register and rx_valid = 1 for exactly one cycle, both on the clock edge after the sample.
REQ-019 STOP sample = 0: rx_frame_err pulses for one cycle, rx_valid stays 0, and rx_data is unchanged.
REQ-020 Parity mismatch with a good stop bit: rx_parity_err pulses, rx_valid stays 0, and rx_data is unchanged.
REQ-021 Frame error takes precedence: when both errors occur, only rx_frame_err pulses.
REQ-022 Start edges seen outside IDLE are ignored; none are queued.
REQ-023 An edge detected in the cycle the FSM returns to IDLE is ignored; the start edge must be seen while in IDLE.
REQ-024 clk_bps pulses while in IDLE are ignored.
REQ-025 bps_start is registered and glitch-free; it is high only in START, DATA, PARITY and STOP.
REQ-026 rx_valid, rx_frame_err and rx_parity_err are mutually exclusive; at most one pulses per frame.

Reset
REQ-027 While rst = 1 at a clk edge: state = IDLE; bps_start, rx_valid, rx_frame_err, rx_parity_err = 0; rx_data = 8'h00; shift register and counter = 0.
REQ-028 Reset sets the synchronizer and history flops to 1, so no false start edge is detected after reset.
REQ-029 Reset mid-frame aborts the frame without any pulse; reception resumes only at the next falling edge after rst deasserts.

Configuration
REQ-030 Macro RX_PARITY_EN defined: one even-parity bit follows D7 and is sampled in PARITY on one clk_bps; mismatch = XOR of D0..D7 and the parity bit equals 1.
REQ-031 Macro RX_PARITY_EN undefined: the PARITY state and its logic are absent, the frame is 8N1, and rx_parity_err is tied to 0.

Verification (bench pairs this block with the baud-rate divider at 433/216, 434 clk per bit)
REQ-032 8N1 frame 0xA5 -> single rx_valid pulse, rx_data = 8'hA5; bps_start falls in the same cycle the stop bit is sampled.
REQ-033 Line low for 100 clk then high -> no output pulse; bps_start returns to 0 at the first clk_bps.
REQ-034 Frame 0x3C with stop bit driven low -> rx_frame_err pulse, rx_valid = 0, rx_data keeps its previous value 8'hA5.
REQ-035 rst asserted for 1 cycle during bit D3 of 0xFF -> all outputs 0; the next frame 0x01 is received correctly.
REQ-036 Back-to-back frames 0x55 then 0xAA with no idle gap -> two rx_valid pulses carrying 8'h55 then 8'hAA.
REQ-037 RX_PARITY_EN, frame 0x07 with parity bit 0 -> rx_parity_err pulse; with parity bit 1 -> rx_valid with rx_data = 8'h07.

Source files
------------

// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronizes rs232_rx, detects the start edge and assembles 8N1 frames.
// Define RX_PARITY_EN to expect one even-parity bit between D7 and the stop bit.
module uart_rx_frame #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs232_rx,
  input  logic       clk_bps,
  output logic       bps_start,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_parity_err
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   bps_start_q, bps_start_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_frame_err_q, rx_frame_err_d;
`ifdef RX_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   rx_parity_err_q, rx_parity_err_d;
`endif

  logic synced;
  logic start_edge;

  assign synced     = sync_q[SYNC_STAGES-1];
  assign start_edge = hist_q & ~synced;

  // Next-state, datapath and pulse outputs; pulses default low every cycle.
  always_comb begin
    state_d        = state_q;
    sync_d         = {sync_q[SYNC_STAGES-2:0], rs232_rx};
    hist_d         = synced;
    shift_d        = shift_q;
    cnt_d          = cnt_q;
    rx_data_d      = rx_data_q;
    bps_start_d    = bps_start_q;
    rx_valid_d     = 1'b0;
    rx_frame_err_d = 1'b0;
`ifdef RX_PARITY_EN
    par_bad_d       = par_bad_q;
    rx_parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d     = START;
          bps_start_d = 1'b1;
        end
      end
      START: begin
        if (clk_bps) begin
          if (synced) begin
            state_d     = IDLE;
            bps_start_d = 1'b0;
          end else begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
      end
      DATA: begin
        if (clk_bps) begin
          shift_d = {synced, shift_q[DATA_W-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (clk_bps) begin
          par_bad_d = ^{shift_q, synced};
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (clk_bps) begin
          state_d     = IDLE;
          bps_start_d = 1'b0;
          // A bad stop bit overrides any parity result.
          if (!synced) begin
            rx_frame_err_d = 1'b1;
          end
`ifdef RX_PARITY_EN
          else if (par_bad_q) begin
            rx_parity_err_d = 1'b1;
          end
`endif
          else begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        bps_start_d = 1'b0;
      end
    endcase
  end

  // Synchronizer idles high after reset so no spurious start edge is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      sync_q         <= '1;
      hist_q         <= 1'b1;
      shift_q        <= '0;
      cnt_q          <= '0;
      rx_data_q      <= '0;
      bps_start_q    <= 1'b0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
`ifdef RX_PARITY_EN
      par_bad_q       <= 1'b0;
      rx_parity_err_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      hist_q         <= hist_d;
      shift_q        <= shift_d;
      cnt_q          <= cnt_d;
      rx_data_q      <= rx_data_d;
      bps_start_q    <= bps_start_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
`ifdef RX_PARITY_EN
      par_bad_q       <= par_bad_d;
      rx_parity_err_q <= rx_parity_err_d;
`endif
    end
  end

  assign bps_start    = bps_start_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
`ifdef RX_PARITY_EN
  assign rx_parity_err = rx_parity_err_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame with a 434-clock-per-bit baud divider model (pulse at count 216).
module tb_uart_rx_frame;

  localparam int unsigned BIT_CLKS = 434;
  localparam int unsigned HALF     = 216;

  logic       clk = 1'b0;
  logic       rst;
  logic       rs232_rx;
  logic       clk_bps;
  logic       bps_start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_parity_err;

  uart_rx_frame #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .rs232_rx     (rs232_rx),
    .clk_bps      (clk_bps),
    .bps_start    (bps_start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err)
  );

  always #10 clk = ~clk;

  // Baud-rate divider: runs only while bps_start is high.
  int unsigned div_cnt = 0;
  always @(posedge clk) begin
    if (rst || !bps_start) div_cnt <= 0;
    else if (div_cnt == BIT_CLKS - 1) div_cnt <= 0;
    else div_cnt <= div_cnt + 1;
  end
  assign clk_bps = bps_start && (div_cnt == HALF);

  // Event monitor: pulse counts and protocol sanity counters.
  int   n_valid = 0, n_ferr = 0, n_perr = 0, n_bps = 0;
  int   overlap_bad = 0, fall_bad = 0;
  logic prev_bps = 1'b0;
  always @(posedge clk) begin
    if (rx_valid) begin
      n_valid <= n_valid + 1;
      if (bps_start || !prev_bps) fall_bad <= fall_bad + 1;
    end
    if (rx_frame_err)  n_ferr <= n_ferr + 1;
    if (rx_parity_err) n_perr <= n_perr + 1;
    if (32'(rx_valid) + 32'(rx_frame_err) + 32'(rx_parity_err) > 1) overlap_bad <= overlap_bad + 1;
    if (clk_bps) n_bps <= n_bps + 1;
    prev_bps <= bps_start;
  end

  int n_total = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one frame; caller is aligned to a falling clock edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    rs232_rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
`ifdef RX_PARITY_EN
    rs232_rx = (^d) ^ par_flip;
    repeat (BIT_CLKS) @(negedge clk);
`endif
    rs232_rx = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
    rs232_rx = 1'b1;
  endtask

  // Reference model state and snapshot of monitor counts.
  logic [7:0] model_data = 8'h00;
  int b_valid, b_ferr, b_perr, b_bps;

  task automatic snap();
    b_valid = n_valid; b_ferr = n_ferr; b_perr = n_perr; b_bps = n_bps;
  endtask

  // Expected outcome of a frame, derived from the stop bit and the parity flip.
  task automatic check_frame(input string tag, input logic [7:0] d, input logic stop_bit,
                             input logic par_flip);
    int ev, ef, ep;
    ev = 0; ef = 0; ep = 0;
    if (!stop_bit) ef = 1;
    else if (par_flip) ep = 1;
    else begin ev = 1; model_data = d; end
    check({tag, ".valid"}, 32'(n_valid - b_valid), 32'(ev));
    check({tag, ".ferr"},  32'(n_ferr - b_ferr),   32'(ef));
    check({tag, ".perr"},  32'(n_perr - b_perr),   32'(ep));
    check({tag, ".data"},  32'(rx_data),           32'(model_data));
  endtask

  initial begin
    logic [7:0] d;
    logic       sb, pf;
    int         gap;

    rst      = 1'b1;
    rs232_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.bps_start", 32'(bps_start), 0);
    check("rst.rx_data", 32'(rx_data), 0);
    check("rst.rx_valid", 32'(rx_valid), 0);
    check("rst.frame_err", 32'(rx_frame_err), 0);
    check("rst.parity_err", 32'(rx_parity_err), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst.no_false_start", 32'(bps_start), 0);

    // Good frame 0xA5
    snap();
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (50) @(negedge clk);
    check_frame("a5", 8'hA5, 1'b1, 1'b0);
    check("a5.bps_fall_with_valid", 32'(fall_bad), 0);
    check("a5.bps_idle", 32'(bps_start), 0);

    // False start: line low for 100 clocks only
    snap();
    rs232_rx = 1'b0;
    repeat (100) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (400) @(negedge clk);
    check("false.valid", 32'(n_valid - b_valid), 0);
    check("false.ferr", 32'(n_ferr - b_ferr), 0);
    check("false.bps_pulses", 32'(n_bps - b_bps), 1);
    check("false.bps_start", 32'(bps_start), 0);

    // Stop bit low on 0x3C
    snap();
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (50) @(negedge clk);
    check_frame("ferr3c", 8'h3C, 1'b0, 1'b0);

    // Reset during D3 of 0xFF
    snap();
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (4 * BIT_CLKS + 150) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.bps_start", 32'(bps_start), 0);
        check("midrst.rx_data", 32'(rx_data), 0);
        check("midrst.rx_valid", 32'(rx_valid), 0);
        check("midrst.frame_err", 32'(rx_frame_err), 0);
      end
    join
    model_data = 8'h00;
    repeat (50) @(negedge clk);
    check("midrst.no_valid", 32'(n_valid - b_valid), 0);
    check("midrst.no_ferr", 32'(n_ferr - b_ferr), 0);
    check("midrst.no_perr", 32'(n_perr - b_perr), 0);
    snap();
    send_frame(8'h01, 1'b1, 1'b0);
    repeat (50) @(negedge clk);
    check_frame("after_rst01", 8'h01, 1'b1, 1'b0);

    // Back-to-back 0x55, 0xAA
    snap();
    send_frame(8'h55, 1'b1, 1'b0);
    check_frame("b2b55", 8'h55, 1'b1, 1'b0);
    snap();
    send_frame(8'hAA, 1'b1, 1'b0);
    repeat (50) @(negedge clk);
    check_frame("b2bAA", 8'hAA, 1'b1, 1'b0);

`ifdef RX_PARITY_EN
    // 0x07 has odd weight, so the even-parity bit is 1; sending 0 is a mismatch
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (50) @(negedge clk);
    check_frame("par07_bad", 8'h07, 1'b1, 1'b1);
    snap();
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (50) @(negedge clk);
    check_frame("par07_good", 8'h07, 1'b1, 1'b0);
    snap();
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (50) @(negedge clk);
    check_frame("par07_both", 8'h07, 1'b0, 1'b1);
`endif

    // Randomized frames against the reference model
    for (int k = 0; k < 6; k++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
`ifdef RX_PARITY_EN
      pf = 1'($urandom_range(0, 1));
`else
      pf = 1'b0;
`endif
      gap = sb ? int'($urandom_range(0, 300)) : int'($urandom_range(20, 300));
      snap();
      send_frame(d, sb, pf);
      repeat (gap) @(negedge clk);
      check_frame($sformatf("rand%0d", k), d, sb, pf);
    end

    repeat (20) @(negedge clk);
    check("overlap_pulses", 32'(overlap_bad), 0);
    check("valid_bps_align", 32'(fall_bad), 0);
    check("end.bps_idle", 32'(bps_start), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
